// File: rtl/irq_ack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ack_pkg
//  Purpose  : Shared definitions for the interrupt request/acknowledge
//             controller: FSM state encoding, default NMI ID and the
//             ID width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package irq_ack_pkg;

    localparam int DEFAULT_NUM_IRQ = 32;
    localparam int DEFAULT_NMI_ID  = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CLR  = 2'd2
    } state_e;

    // Width of an interrupt ID; a single line still needs one bit.
    function automatic int calc_id_width(input int num_irq);
        return (num_irq > 1) ? $clog2(num_irq) : 1;
    endfunction

    localparam int DEFAULT_ID_WIDTH = calc_id_width(DEFAULT_NUM_IRQ);

endpackage
`default_nettype wire

// File: rtl/irq_ack_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ack_ctrl_if
//  Purpose  : Bundles the interrupt buffer status/clear signals and the core
//             request/acknowledge handshake of the controller.
//  Ports    : irq_pending_i, nmi_pending_i  - buffered status into controller
//             irq_req_o, irq_id_o           - request to the core
//             irq_ack_i, irq_ack_id_i       - acknowledge from the core
//             irq_clear_o, nmi_clear_o      - clear pulses to the buffers
//             ack_err_o                     - acknowledge error pulse
//             modport slave  : controller side
//             modport master : core/buffer side
//  Revision : 1.0 - initial release
// ============================================================================
interface irq_ack_ctrl_if
    import irq_ack_pkg::*;
#(
    parameter int NUM_IRQ  = DEFAULT_NUM_IRQ,
    parameter int ID_WIDTH = calc_id_width(NUM_IRQ)
);
    logic [NUM_IRQ-1:0]  irq_pending_i;
    logic                nmi_pending_i;
    logic                irq_req_o;
    logic [ID_WIDTH-1:0] irq_id_o;
    logic                irq_ack_i;
    logic [ID_WIDTH-1:0] irq_ack_id_i;
    logic [NUM_IRQ-1:0]  irq_clear_o;
    logic                nmi_clear_o;
    logic                ack_err_o;

    modport slave (
        input  irq_pending_i,
        input  nmi_pending_i,
        input  irq_ack_i,
        input  irq_ack_id_i,
        output irq_req_o,
        output irq_id_o,
        output irq_clear_o,
        output nmi_clear_o,
        output ack_err_o
    );

    modport master (
        output irq_pending_i,
        output nmi_pending_i,
        output irq_ack_i,
        output irq_ack_id_i,
        input  irq_req_o,
        input  irq_id_o,
        input  irq_clear_o,
        input  nmi_clear_o,
        input  ack_err_o
    );

endinterface
`default_nettype wire

// File: rtl/rr_find_first.sv
`default_nettype none
// ============================================================================
//  Module   : rr_find_first
//  Purpose  : Combinational round-robin search. Returns the first set bit of
//             vec found searching upward from start_ptr, wrapping modulo
//             NUM_IRQ (NUM_IRQ must be a power of two).
//  Ports    : vec       in  NUM_IRQ   candidate vector
//             start_ptr in  ID_WIDTH  first index to examine
//             idx       out ID_WIDTH  index of the first set bit
//             found     out 1         any bit of vec set
//  Revision : 1.0 - initial release
// ============================================================================
module rr_find_first
    import irq_ack_pkg::*;
#(
    parameter int NUM_IRQ  = DEFAULT_NUM_IRQ,
    parameter int ID_WIDTH = calc_id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0]  vec,
    input  logic [ID_WIDTH-1:0] start_ptr,
    output logic [ID_WIDTH-1:0] idx,
    output logic                found
);

    logic [NUM_IRQ-1:0]  w_rot;
    logic [ID_WIDTH-1:0] w_off;

    // Rotate so that start_ptr lands on bit 0; index arithmetic wraps
    // naturally because NUM_IRQ is a power of two.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_rot[i] = vec[ID_WIDTH'(ID_WIDTH'(i) + start_ptr)];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward lets the
    // last assignment win without a break.
    always_comb begin
        w_off = '0;
        found = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

    assign idx = w_off + start_ptr;

endmodule
`default_nettype wire

// File: rtl/irq_ack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ack_ctrl
//  Purpose  : Core-side interrupt request/acknowledge controller. Presents one
//             request at a time (NMI first, then round-robin maskable IRQs),
//             completes the acknowledge handshake and issues a one-cycle
//             one-hot clear back into the interrupt buffer.
//  Ports    : clk_i   in  clock
//             rst_ni  in  asynchronous active-low reset
//             bus     slave modport of irq_ack_ctrl_if
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ack_ctrl
    import irq_ack_pkg::*;
#(
    parameter int NUM_IRQ  = DEFAULT_NUM_IRQ,
    parameter int ID_WIDTH = calc_id_width(NUM_IRQ),
    parameter int NMI_ID   = DEFAULT_NMI_ID
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    irq_ack_ctrl_if.slave  bus
);

    localparam logic [1:0]          c_idle   = ST_IDLE;
    localparam logic [1:0]          c_req    = ST_REQ;
    localparam logic [1:0]          c_clr    = ST_CLR;
    localparam logic [ID_WIDTH-1:0] c_nmi_id = ID_WIDTH'(NMI_ID);
    localparam logic [NUM_IRQ-1:0]  c_one    = NUM_IRQ'(1);
    // The NMI_ID slot of the maskable vector is reserved for the NMI.
    localparam logic [NUM_IRQ-1:0]  c_irq_mask = ~(c_one << NMI_ID);

    logic [1:0]          r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_nmi;
    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic                r_ack_err;

    logic [NUM_IRQ-1:0]  w_irq_vec;
    logic [ID_WIDTH-1:0] w_rr_idx;
    logic                w_rr_found;
    logic                w_ack_match;
    logic                w_src_dropped;

    assign w_irq_vec = bus.irq_pending_i & c_irq_mask;

    rr_find_first #(
        .NUM_IRQ  (NUM_IRQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_find_first (
        .vec       (w_irq_vec),
        .start_ptr (r_rr_ptr),
        .idx       (w_rr_idx),
        .found     (w_rr_found)
    );

    assign w_ack_match   = bus.irq_ack_i && (bus.irq_ack_id_i == r_id);
    assign w_src_dropped = r_nmi ? !bus.nmi_pending_i : !w_irq_vec[r_id];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_idle;
            r_id      <= '0;
            r_nmi     <= 1'b0;
            r_rr_ptr  <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_ack_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_ack_err <= bus.irq_ack_i;
                    if (bus.nmi_pending_i) begin
                        r_id    <= c_nmi_id;
                        r_nmi   <= 1'b1;
                        r_state <= c_req;
                    end else if (w_rr_found) begin
                        r_id    <= w_rr_idx;
                        r_nmi   <= 1'b0;
                        r_state <= c_req;
                    end
                end
                c_req: begin
                    if (w_ack_match) begin
                        r_state <= c_clr;
                        // NMI service does not disturb the round-robin order.
                        if (!r_nmi) begin
                            r_rr_ptr <= r_id + 1'b1;
                        end
                    end else if (bus.irq_ack_i) begin
                        r_ack_err <= 1'b1;
                        r_state   <= c_idle;
                    end else if (!r_nmi && bus.nmi_pending_i) begin
                        // Preempt in place: the request line stays high.
                        r_id  <= c_nmi_id;
                        r_nmi <= 1'b1;
                    end else if (w_src_dropped) begin
                        r_state <= c_idle;
                    end
                end
                c_clr: begin
                    // The buffer sees the clear at the next edge, so going
                    // through IDLE first avoids re-requesting a stale bit.
                    r_ack_err <= bus.irq_ack_i;
                    r_state   <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state.
    assign bus.irq_req_o   = (r_state == c_req);
    assign bus.irq_id_o    = r_id;
    assign bus.irq_clear_o = ((r_state == c_clr) && !r_nmi) ? (c_one << r_id) : '0;
    assign bus.nmi_clear_o = (r_state == c_clr) && r_nmi;
    assign bus.ack_err_o   = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_ack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ack_ctrl
//  Purpose  : Self-checking bench for irq_ack_ctrl: directed scenarios plus a
//             randomized run against a transaction-level reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ack_ctrl;
    import irq_ack_pkg::*;

    localparam int N   = 32;
    localparam int W   = 5;
    localparam int NMI = 31;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    irq_ack_ctrl_if #(.NUM_IRQ(N), .ID_WIDTH(W)) bus();

    irq_ack_ctrl #(.NUM_IRQ(N), .ID_WIDTH(W), .NMI_ID(NMI)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic         m_busy, m_nmi, m_clr, m_clr_nmi, m_err;
    logic [W-1:0] m_id, m_clr_id;
    int           m_ptr;

    function automatic int pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (((ptr + k) % N) != NMI && pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy <= 0; m_nmi <= 0; m_clr <= 0; m_clr_nmi <= 0; m_err <= 0;
            m_id <= '0; m_clr_id <= '0; m_ptr <= 0;
        end else begin
            m_err <= bus.irq_ack_i && !(m_busy && bus.irq_ack_id_i == m_id);
            m_clr <= 1'b0;
            if (m_clr) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (bus.nmi_pending_i) begin
                    m_busy <= 1'b1; m_id <= W'(NMI); m_nmi <= 1'b1;
                end else if (pick(bus.irq_pending_i, m_ptr) >= 0) begin
                    m_busy <= 1'b1; m_id <= W'(pick(bus.irq_pending_i, m_ptr)); m_nmi <= 1'b0;
                end
            end else if (bus.irq_ack_i && bus.irq_ack_id_i == m_id) begin
                m_busy <= 1'b0; m_clr <= 1'b1; m_clr_nmi <= m_nmi; m_clr_id <= m_id;
                if (!m_nmi) m_ptr <= (int'(m_id) + 1) % N;
            end else if (bus.irq_ack_i) begin
                m_busy <= 1'b0;
            end else if (!m_nmi && bus.nmi_pending_i) begin
                m_id <= W'(NMI); m_nmi <= 1'b1;
            end else if (m_nmi ? !bus.nmi_pending_i : !bus.irq_pending_i[m_id]) begin
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        bus.irq_pending_i = '0;
        bus.nmi_pending_i = 1'b0;
        bus.irq_ack_i     = 1'b0;
        bus.irq_ack_id_i  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        step(); step();
        n_cmp++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b want=0", bus.irq_req_o); end
        n_cmp++; if (bus.irq_id_o !== '0) begin n_err++; $display("FAIL reset_id got=%0d want=0", bus.irq_id_o); end
        n_cmp++; if (bus.irq_clear_o !== '0) begin n_err++; $display("FAIL reset_clear got=%h want=0", bus.irq_clear_o); end
        n_cmp++; if (bus.nmi_clear_o !== 1'b0) begin n_err++; $display("FAIL reset_nmi_clear got=%0b want=0", bus.nmi_clear_o); end
        n_cmp++; if (bus.ack_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ack_err got=%0b want=0", bus.ack_err_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.irq_pending_i = 32'h8;
        step();
        n_cmp++; if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 5'd3) begin n_err++; $display("FAIL single_req got req=%0b id=%0d want req=1 id=3", bus.irq_req_o, bus.irq_id_o); end
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd3;
        step();
        n_cmp++; if (bus.irq_clear_o !== 32'h8 || bus.irq_req_o !== 1'b0 || bus.ack_err_o !== 1'b0) begin n_err++; $display("FAIL single_clear got clr=%h req=%0b err=%0b want clr=8 req=0 err=0", bus.irq_clear_o, bus.irq_req_o, bus.ack_err_o); end
        bus.irq_ack_i = 1'b0; bus.irq_pending_i = '0;
        step();
        n_cmp++; if (bus.irq_clear_o !== '0 || bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL single_after1 got clr=%h req=%0b want 0/0", bus.irq_clear_o, bus.irq_req_o); end
        step();
        n_cmp++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL single_after2 got req=%0b want 0", bus.irq_req_o); end
    endtask

    // Services a held pending vector and compares the sequence of IDs.
    task automatic test_round_robin(input logic [N-1:0] pend, input int n, input int e0, input int e1, input int e2, input int e3);
        int exp_ids[4];
        int waited;
        exp_ids = '{e0, e1, e2, e3};
        do_reset();
        bus.irq_pending_i = pend;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (bus.irq_req_o !== 1'b1 && waited < 4) begin step(); waited++; end
            n_cmp++;
            if (bus.irq_req_o !== 1'b1) begin
                n_err++; $display("FAIL rr_timeout service=%0d req never rose", i);
            end else if (int'(bus.irq_id_o) != exp_ids[i]) begin
                n_err++; $display("FAIL rr_order service=%0d got id=%0d want id=%0d", i, bus.irq_id_o, exp_ids[i]);
            end
            bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = W'(exp_ids[i]);
            step();
            bus.irq_ack_i = 1'b0;
            n_cmp++; if (bus.irq_clear_o !== (N'(1) << exp_ids[i])) begin n_err++; $display("FAIL rr_clear service=%0d got %h want %h", i, bus.irq_clear_o, N'(1) << exp_ids[i]); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_nmi_preempt();
        do_reset();
        bus.irq_pending_i = 32'h20;
        step();
        n_cmp++; if (bus.irq_id_o !== 5'd5 || bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmi_pre_id got id=%0d req=%0b want 5/1", bus.irq_id_o, bus.irq_req_o); end
        bus.nmi_pending_i = 1'b1;
        step();
        n_cmp++; if (bus.irq_id_o !== 5'd31 || bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmi_preempt got id=%0d req=%0b want 31/1", bus.irq_id_o, bus.irq_req_o); end
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd31;
        step();
        n_cmp++; if (bus.nmi_clear_o !== 1'b1 || bus.irq_clear_o !== '0) begin n_err++; $display("FAIL nmi_clear got nclr=%0b clr=%h want 1/0", bus.nmi_clear_o, bus.irq_clear_o); end
        bus.irq_ack_i = 1'b0; bus.nmi_pending_i = 1'b0;
        step();
        n_cmp++; if (bus.nmi_clear_o !== 1'b0 || bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nmi_idle got nclr=%0b req=%0b want 0/0", bus.nmi_clear_o, bus.irq_req_o); end
        step();
        n_cmp++; if (bus.irq_id_o !== 5'd5 || bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmi_resume got id=%0d req=%0b want 5/1", bus.irq_id_o, bus.irq_req_o); end
        clear_inputs();
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.irq_pending_i = 32'h4;
        step();
        n_cmp++; if (bus.irq_id_o !== 5'd2 || bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL wd_req got id=%0d req=%0b want 2/1", bus.irq_id_o, bus.irq_req_o); end
        bus.irq_pending_i = '0;
        step();
        n_cmp++; if (bus.irq_req_o !== 1'b0 || bus.ack_err_o !== 1'b0 || bus.irq_clear_o !== '0) begin n_err++; $display("FAIL wd_drop got req=%0b err=%0b clr=%h want 0/0/0", bus.irq_req_o, bus.ack_err_o, bus.irq_clear_o); end
        step();
        n_cmp++; if (bus.irq_clear_o !== '0 || bus.ack_err_o !== 1'b0) begin n_err++; $display("FAIL wd_after got clr=%h err=%0b want 0/0", bus.irq_clear_o, bus.ack_err_o); end
    endtask

    task automatic test_bad_ack();
        do_reset();
        bus.irq_pending_i = 32'h80;
        step();
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd6;
        step();
        n_cmp++; if (bus.ack_err_o !== 1'b1 || bus.irq_clear_o !== '0 || bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL bad_ack got err=%0b clr=%h req=%0b want 1/0/0", bus.ack_err_o, bus.irq_clear_o, bus.irq_req_o); end
        bus.irq_ack_i = 1'b0; bus.irq_pending_i = '0;
        step();
        n_cmp++; if (bus.ack_err_o !== 1'b0 || bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL bad_ack_pulse got err=%0b req=%0b want 0/0", bus.ack_err_o, bus.irq_req_o); end
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd0;
        step();
        n_cmp++; if (bus.ack_err_o !== 1'b1) begin n_err++; $display("FAIL idle_ack got err=%0b want 1", bus.ack_err_o); end
        bus.irq_ack_i = 1'b0;
        step();
        n_cmp++; if (bus.ack_err_o !== 1'b0) begin n_err++; $display("FAIL idle_ack_pulse got err=%0b want 0", bus.ack_err_o); end
    endtask

    task automatic test_reset_mid_clr();
        do_reset();
        bus.irq_pending_i = 32'h0010_0200;   // bits 9 and 20
        step();
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd9;
        step();
        n_cmp++; if (bus.irq_clear_o !== 32'h200) begin n_err++; $display("FAIL rmc_clr got %h want 200", bus.irq_clear_o); end
        bus.irq_ack_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.irq_clear_o !== '0 || bus.irq_req_o !== 1'b0 || bus.nmi_clear_o !== 1'b0 || bus.ack_err_o !== 1'b0) begin n_err++; $display("FAIL rmc_async got clr=%h req=%0b want 0/0", bus.irq_clear_o, bus.irq_req_o); end
        step();
        rst_ni = 1'b1;
        step();
        n_cmp++; if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 5'd9) begin n_err++; $display("FAIL rmc_reissue got req=%0b id=%0d want 1/9", bus.irq_req_o, bus.irq_id_o); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] buf_v;
        logic         nbuf;
        logic [N-1:0] exp_clr;
        int           r;
        do_reset();
        buf_v = '0; nbuf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            exp_clr = (m_clr && !m_clr_nmi) ? (N'(1) << m_clr_id) : '0;
            n_cmp++; if (bus.irq_req_o !== m_busy) begin n_err++; $display("FAIL rnd_req cyc=%0d got %0b want %0b", c, bus.irq_req_o, m_busy); end
            n_cmp++; if (bus.irq_clear_o !== exp_clr) begin n_err++; $display("FAIL rnd_clear cyc=%0d got %h want %h", c, bus.irq_clear_o, exp_clr); end
            n_cmp++; if (bus.nmi_clear_o !== (m_clr && m_clr_nmi)) begin n_err++; $display("FAIL rnd_nmi_clear cyc=%0d got %0b want %0b", c, bus.nmi_clear_o, m_clr && m_clr_nmi); end
            n_cmp++; if (bus.ack_err_o !== m_err) begin n_err++; $display("FAIL rnd_ack_err cyc=%0d got %0b want %0b", c, bus.ack_err_o, m_err); end
            if (m_busy) begin
                n_cmp++; if (bus.irq_id_o !== m_id) begin n_err++; $display("FAIL rnd_id cyc=%0d got %0d want %0d", c, bus.irq_id_o, m_id); end
            end
            // Buffer environment: registered clear, sparse new events, rare drops.
            buf_v = buf_v & ~bus.irq_clear_o;
            if ($urandom_range(0, 3) == 0) buf_v = buf_v | (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(0, 15) == 0) buf_v = buf_v & N'($urandom);
            nbuf = nbuf & ~bus.nmi_clear_o;
            if ($urandom_range(0, 40) == 0) nbuf = 1'b1;
            if ($urandom_range(0, 30) == 0) nbuf = 1'b0;
            bus.irq_pending_i = buf_v;
            bus.nmi_pending_i = nbuf;
            r = int'($urandom_range(0, 9));
            bus.irq_ack_i = 1'b0;
            if (bus.irq_req_o && r < 4) begin
                bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = bus.irq_id_o;
            end else if (bus.irq_req_o && r == 4) begin
                bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = W'($urandom);
            end else if (r == 9 && $urandom_range(0, 3) == 0) begin
                bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = W'($urandom);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin(32'h0000_0011, 4, 0, 4, 0, 4);
        test_round_robin(32'hC000_0001, 3, 0, 30, 0, 0);
        test_nmi_preempt();
        test_withdraw();
        test_bad_ack();
        test_reset_mid_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
